// File: rtl/even_odd_sequence_gen.sv
// Source-side stream generator: emits a run of all-even or all-odd numbers
// over a valid/ready handshake, with a parity flag (1 = EVEN) on every word.
module even_odd_sequence_gen #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned COUNT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               odd_sel,
  input  logic [WIDTH-1:0]   start_val,
  input  logic [COUNT_W-1:0] run_len,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_number,
  output logic               out_even,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_number_q, out_number_d;
  logic               out_even_q, out_even_d;
  logic               busy_q, busy_d;
  logic [COUNT_W-1:0] remaining_q, remaining_d;

  always_comb begin
    state_d      = state_q;
    out_valid_d  = out_valid_q;
    out_number_d = out_number_q;
    out_even_d   = out_even_q;
    busy_d       = busy_q;
    remaining_d  = remaining_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          if (run_len != '0) begin
            state_d      = RUN;
            out_number_d = {start_val[WIDTH-1:1], odd_sel};
            out_even_d   = ~odd_sel;
            out_valid_d  = 1'b1;
            remaining_d  = run_len;
          end else begin
            state_d = FIN;
          end
        end
      end
      RUN: begin
        if (out_valid_q && out_ready) begin
          if (remaining_q > COUNT_W'(1)) begin
            // +2 keeps the LSB, so parity survives the modulo wrap
            out_number_d = out_number_q + WIDTH'(2);
            out_even_d   = ~out_number_d[0];
            remaining_d  = remaining_q - COUNT_W'(1);
          end else begin
            state_d     = FIN;
            out_valid_d = 1'b0;
            remaining_d = '0;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      out_valid_q  <= 1'b0;
      out_number_q <= '0;
      out_even_q   <= 1'b1;
      busy_q       <= 1'b0;
      remaining_q  <= '0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      out_number_q <= out_number_d;
      out_even_q   <= out_even_d;
      busy_q       <= busy_d;
      remaining_q  <= remaining_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_number = out_number_q;
  assign out_even   = out_even_q;
  assign busy       = busy_q;
  assign done       = (state_q == FIN);

endmodule

// File: tb/tb_even_odd_sequence_gen.sv
// Directed bench for even_odd_sequence_gen: inputs change and outputs are
// sampled on the falling edge, away from the rising active edge.
module tb_even_odd_sequence_gen;

  logic       clk;
  logic       rst;
  logic       start;
  logic       odd_sel;
  logic [3:0] start_val;
  logic [4:0] run_len;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_number;
  logic       out_even;
  logic       busy;
  logic       done;

  int pass_cnt;
  int total_cnt;
  int hs_cnt;

  even_odd_sequence_gen #(.WIDTH(4), .COUNT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .odd_sel   (odd_sel),
    .start_val (start_val),
    .run_len   (run_len),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_number(out_number),
    .out_even  (out_even),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) hs_cnt++;
  end

  // Called at a falling edge; start is seen by exactly one rising edge.
  task automatic do_start(input logic odd, input logic [3:0] val, input logic [4:0] len);
    start     = 1'b1;
    odd_sel   = odd;
    start_val = val;
    run_len   = len;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    total_cnt++;
    if ({out_valid, out_number, out_even, busy, done} !== {1'b0, 4'd0, 1'b1, 1'b0, 1'b0})
      $display("FAIL reset: got v=%b n=%0d e=%b busy=%b done=%b, want v=0 n=0 e=1 busy=0 done=0",
               out_valid, out_number, out_even, busy, done);
    else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Shared by the plain even run and the start-while-busy scenario.
  task automatic even_run_body(input bit inject, input string tag);
    logic [3:0] exp_n;
    int hs0;
    out_ready = 1'b1;
    hs0 = hs_cnt;
    do_start(1'b0, 4'd0, 5'd8);
    for (int i = 0; i < 8; i++) begin
      exp_n = 4'(2 * i);
      total_cnt++;
      if ({out_valid, out_number, out_even, busy, done} !== {1'b1, exp_n, 1'b1, 1'b1, 1'b0})
        $display("FAIL %s_word%0d: got v=%b n=%0d e=%b busy=%b done=%b, want v=1 n=%0d e=1 busy=1 done=0",
                 tag, i, out_valid, out_number, out_even, busy, done, exp_n);
      else pass_cnt++;
      if (inject && i == 3) begin
        start = 1'b1; odd_sel = 1'b1; start_val = 4'd5; run_len = 5'd2;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    total_cnt++;
    if ({out_valid, busy, done} !== 3'b011)
      $display("FAIL %s_done: got v=%b busy=%b done=%b, want v=0 busy=1 done=1", tag, out_valid, busy, done);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({out_valid, busy, done} !== 3'b000)
      $display("FAIL %s_idle: got v=%b busy=%b done=%b, want v=0 busy=0 done=0", tag, out_valid, busy, done);
    else pass_cnt++;
    total_cnt++;
    if (hs_cnt - hs0 !== 8)
      $display("FAIL %s_handshakes: got %0d, want 8", tag, hs_cnt - hs0);
    else pass_cnt++;
  endtask

  task automatic test_even_run();
    even_run_body(1'b0, "even_run");
  endtask

  task automatic test_start_while_busy();
    even_run_body(1'b1, "start_busy");
  endtask

  task automatic test_odd_wrap();
    logic [3:0] exp_n;
    out_ready = 1'b1;
    do_start(1'b1, 4'd14, 5'd3);
    for (int i = 0; i < 3; i++) begin
      exp_n = 4'd15 + 4'(2 * i);
      total_cnt++;
      if ({out_valid, out_number, out_even, busy, done} !== {1'b1, exp_n, 1'b0, 1'b1, 1'b0})
        $display("FAIL odd_wrap_word%0d: got v=%b n=%0d e=%b busy=%b done=%b, want v=1 n=%0d e=0 busy=1 done=0",
                 i, out_valid, out_number, out_even, busy, done, exp_n);
      else pass_cnt++;
      @(negedge clk);
    end
    total_cnt++;
    if ({out_valid, busy, done} !== 3'b011)
      $display("FAIL odd_wrap_done: got v=%b busy=%b done=%b, want v=0 busy=1 done=1", out_valid, busy, done);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [3:0] exp_seq [6];
    int hs0;
    exp_seq = '{4'd4, 4'd4, 4'd4, 4'd4, 4'd6, 4'd8};
    out_ready = 1'b0;
    hs0 = hs_cnt;
    do_start(1'b0, 4'd4, 5'd3);
    for (int i = 0; i < 6; i++) begin
      total_cnt++;
      if ({out_valid, out_number, out_even, busy, done} !== {1'b1, exp_seq[i], 1'b1, 1'b1, 1'b0})
        $display("FAIL backpressure_cyc%0d: got v=%b n=%0d e=%b busy=%b done=%b, want v=1 n=%0d e=1 busy=1 done=0",
                 i, out_valid, out_number, out_even, busy, done, exp_seq[i]);
      else pass_cnt++;
      if (i == 3) out_ready = 1'b1;
      @(negedge clk);
    end
    total_cnt++;
    if ({out_valid, busy, done} !== 3'b011)
      $display("FAIL backpressure_done: got v=%b busy=%b done=%b, want v=0 busy=1 done=1", out_valid, busy, done);
    else pass_cnt++;
    total_cnt++;
    if (hs_cnt - hs0 !== 3)
      $display("FAIL backpressure_handshakes: got %0d, want 3", hs_cnt - hs0);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_zero_run();
    int hs0;
    out_ready = 1'b1;
    hs0 = hs_cnt;
    do_start(1'b0, 4'd9, 5'd0);
    total_cnt++;
    if ({out_valid, busy, done} !== 3'b011)
      $display("FAIL zero_run_fin: got v=%b busy=%b done=%b, want v=0 busy=1 done=1", out_valid, busy, done);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({out_valid, busy, done} !== 3'b000)
      $display("FAIL zero_run_idle: got v=%b busy=%b done=%b, want v=0 busy=0 done=0", out_valid, busy, done);
    else pass_cnt++;
    total_cnt++;
    if (hs_cnt - hs0 !== 0)
      $display("FAIL zero_run_handshakes: got %0d, want 0", hs_cnt - hs0);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_run();
    logic [3:0] exp_n;
    out_ready = 1'b1;
    do_start(1'b0, 4'd2, 5'd6);
    @(negedge clk);
    @(negedge clk);
    total_cnt++;
    if ({out_valid, out_number} !== {1'b1, 4'd6})
      $display("FAIL mid_run_pre_reset: got v=%b n=%0d, want v=1 n=6", out_valid, out_number);
    else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({out_valid, out_number, out_even, busy, done} !== {1'b0, 4'd0, 1'b1, 1'b0, 1'b0})
      $display("FAIL mid_run_reset: got v=%b n=%0d e=%b busy=%b done=%b, want v=0 n=0 e=1 busy=0 done=0",
               out_valid, out_number, out_even, busy, done);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({out_valid, busy, done} !== 3'b000)
      $display("FAIL mid_run_no_done: got v=%b busy=%b done=%b, want v=0 busy=0 done=0", out_valid, busy, done);
    else pass_cnt++;
    do_start(1'b1, 4'd8, 5'd2);
    for (int i = 0; i < 2; i++) begin
      exp_n = 4'd9 + 4'(2 * i);
      total_cnt++;
      if ({out_valid, out_number, out_even, busy, done} !== {1'b1, exp_n, 1'b0, 1'b1, 1'b0})
        $display("FAIL restart_word%0d: got v=%b n=%0d e=%b busy=%b done=%b, want v=1 n=%0d e=0 busy=1 done=0",
                 i, out_valid, out_number, out_even, busy, done, exp_n);
      else pass_cnt++;
      @(negedge clk);
    end
    total_cnt++;
    if ({out_valid, busy, done} !== 3'b011)
      $display("FAIL restart_done: got v=%b busy=%b done=%b, want v=0 busy=1 done=1", out_valid, busy, done);
    else pass_cnt++;
    @(negedge clk);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    hs_cnt    = 0;
    rst       = 1'b1;
    start     = 1'b0;
    odd_sel   = 1'b0;
    start_val = 4'd0;
    run_len   = 5'd0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_even_run();
    test_odd_wrap();
    test_backpressure();
    test_zero_run();
    test_start_while_busy();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
